mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register plus write-back datapath of the 5-stage MIPS core.
//  Latches MEM-stage results and forms the regfile write port (regwrite/writerd/writedata/pcout_W).
//  Load data is byte/half extracted here. The block sits directly upstream of the register file.
//  Its registered outputs also serve as the W-stage forwarding source.
// PARAMETERS
//  DATA_W  32  datapath / PC width
//  REG_AW  5   register index width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-low reset
//  stall        in   1       1 = hold all W-stage registers
//  flush        in   1       1 = load a bubble into the W stage
//  m_valid      in   1       MEM stage holds a real instruction
//  m_pc         in   DATA_W  PC of MEM-stage instruction
//  m_alu        in   DATA_W  ALU result / effective address
//  m_rdata      in   DATA_W  raw word from data memory
//  m_rd         in   REG_AW  destination register
//  m_regwrite   in   1       instruction writes a register
//  m_wbsel      in   2       0 = ALU, 1 = MEM, 2 = PC+8 (link), 3 = ALU
//  m_ldtype     in   3       0 = LW, 1 = LB, 2 = LBU, 3 = LH, 4 = LHU, others = LW
//  regwrite     out  1       regfile write enable
//  writerd      out  REG_AW  regfile write index
//  writedata    out  DATA_W  regfile write data
//  pcout_W      out  DATA_W  PC of the W-stage instruction (trace/display)
//  w_valid      out  1       W stage holds a real instruction
//  retire_cnt   out  32      retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  - Every register updates on posedge clk. Priority: reset (low) > flush > stall > capture.
//  - Reset: w_valid = 0, regwrite = 0, writerd = 0, writedata = 0, pcout_W = 0, retire_cnt = 0.
//    Every internal field is cleared as well.
//  - Capture: latch all m_* inputs. Latency is exactly 1 cycle from the MEM inputs to the regfile port.
//  - Flush: same values as reset, except retire_cnt holds. Flush overrides stall in the same cycle.
//  - Stall: all fields hold. Outputs are stable, so a held write re-asserts the same value every cycle.
//  - regwrite = w_valid & regwrite_q & (rd_q != 0). A bubble or a $0 target never asserts it.
//  - writerd = rd_q when regwrite is 1, else 0.
//  - writedata is combinational from the registered fields:
//      wbsel 0/3 -> alu_q
//      wbsel 2   -> pc_q + 8, mod 2^DATA_W; wraps at 0xFFFFFFF8 -> 0x00000000
//      wbsel 1   -> load-extend of rdata_q, selected by alu_q[1:0]
//  - Load extract (little-endian):
//      LB/LBU select byte alu_q[1:0]
//      LH/LHU select the half chosen by alu_q[1]; alu_q[0] is ignored (no alignment trap here)
//      LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged
//  - Reset asserted mid-stall clears the stage. The held instruction is dropped, with no write.
// CONFIGURATION
//  Macro: WB_RETIRE_CNT_EN
//  - Defined: retire_cnt += 1 (wrapping at 2^32) on every capture edge with m_valid = 1.
//    It does not count on stall, flush or reset edges.
//  - Undefined: no counter is built and retire_cnt is tied to 32'h0.
// STRUCTURE
//  - Shared package mips_pkg holds:
//      WBSEL_ALU / WBSEL_MEM / WBSEL_LINK encodings
//      LD_LW / LD_LB / LD_LBU / LD_LH / LD_LHU encodings
//      DATA_W and REG_AW defaults
//  - Sub-module load_ext: combinational (rdata, addr_lo[1:0], ldtype) -> 32-bit extended word.
//    It is reused by any future load-forwarding path.
//  - Top: pipeline register, write-back mux, optional counter.
// TESTING
//  1. reset = 0 for 2 cycles, with m_* driven non-zero -> all outputs 0. After reset = 1 and one capture, values appear.
//  2. LB: rdata = 0x80FF7F01, alu[1:0] = 3, wbsel = 1, rd = 5 -> writedata = 0xFFFFFF80, writerd = 5, regwrite = 1.
//     Same with LBU -> writedata = 0x00000080.
//  3. LH: alu[1:0] = 2, rdata = 0x8001_1234 -> writedata = 0xFFFF8001. LHU -> 0x00008001.
//     alu[1:0] = 1 -> 0x00001234 for LH and LHU.
//  4. Link: wbsel = 2, pc = 0x00003000 -> writedata = 0x00003008. pc = 0xFFFFFFF8 -> 0x00000000.
//  5. rd = 0 with m_regwrite = 1 -> regwrite = 0.
//     stall = 1 for 3 cycles -> outputs constant.
//     stall = 1 and flush = 1 -> bubble: w_valid = 0, regwrite = 0.
//  6. With WB_RETIRE_CNT_EN: 10 valid captures, 2 stalls, 1 flush -> retire_cnt = 10.
//     Without the macro: retire_cnt stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: write-back select and load-type encodings plus
// default datapath widths.
package mips_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_AW_DEFAULT = 5;

  // Encoding 3 is not named; the write-back mux treats it as ALU.
  typedef enum logic [1:0] {
    WBSEL_ALU  = 2'd0,
    WBSEL_MEM  = 2'd1,
    WBSEL_LINK = 2'd2
  } wbsel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ldtype_e;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// load_ext: little-endian byte/half extraction and sign/zero extension of a
// loaded word. Pure combinational so load-forwarding paths can reuse it.
module load_ext
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ldtype,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword select ignores addr_lo[0]; misalignment is not trapped here.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (ldtype)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'h0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back datapath feeding the register file.
// Optional retired-instruction counter built when WB_RETIRE_CNT_EN is defined.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_pc,
  input  logic [DATA_W-1:0] m_alu,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_regwrite,
  input  logic [1:0]        m_wbsel,
  input  logic [2:0]        m_ldtype,
  output logic              regwrite,
  output logic [REG_AW-1:0] writerd,
  output logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] pcout_W,
  output logic              w_valid,
  output logic [31:0]       retire_cnt
);

  logic              valid_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;
  logic [REG_AW-1:0] rd_q;
  logic              regwrite_q;
  logic [1:0]        wbsel_q;
  logic [2:0]        ldtype_q;
  logic [31:0]       load_data;

  // Flush loads the same bubble as reset and takes priority over stall.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      wbsel_q    <= 2'd0;
      ldtype_q   <= 3'd0;
    end else if (!stall) begin
      valid_q    <= m_valid;
      pc_q       <= m_pc;
      alu_q      <= m_alu;
      rdata_q    <= m_rdata;
      rd_q       <= m_rd;
      regwrite_q <= m_regwrite;
      wbsel_q    <= m_wbsel;
      ldtype_q   <= m_ldtype;
    end
  end

  load_ext u_load_ext (
    .rdata   (rdata_q),
    .addr_lo (alu_q[1:0]),
    .ldtype  (ldtype_q),
    .data    (load_data)
  );

  always_comb begin
    writedata = alu_q;
    case (wbsel_q)
      WBSEL_MEM:  writedata = load_data;
      WBSEL_LINK: writedata = pc_q + DATA_W'(8);
      default:    writedata = alu_q;
    endcase
  end

  assign regwrite = valid_q & regwrite_q & (rd_q != '0);
  assign writerd  = regwrite ? rd_q : '0;
  assign pcout_W  = pc_q;
  assign w_valid  = valid_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Counts only capture edges; flush and stall edges leave it alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_q <= 32'h0;
    end else if (!flush && !stall && m_valid) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; retire_cnt expectations follow
// WB_RETIRE_CNT_EN.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_alu;
  logic [31:0] m_rdata;
  logic [4:0]  m_rd;
  logic        m_regwrite;
  logic [1:0]  m_wbsel;
  logic [2:0]  m_ldtype;
  logic        regwrite;
  logic [4:0]  writerd;
  logic [31:0] writedata;
  logic [31:0] pcout_W;
  logic        w_valid;
  logic [31:0] retire_cnt;

  int total = 0;
  int bad   = 0;

  mem_wb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_pc       (m_pc),
    .m_alu      (m_alu),
    .m_rdata    (m_rdata),
    .m_rd       (m_rd),
    .m_regwrite (m_regwrite),
    .m_wbsel    (m_wbsel),
    .m_ldtype   (m_ldtype),
    .regwrite   (regwrite),
    .writerd    (writerd),
    .writedata  (writedata),
    .pcout_W    (pcout_W),
    .w_valid    (w_valid),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
                       input logic [1:0] wbsel, input logic [2:0] ld);
    m_valid = v; m_pc = pc; m_alu = alu; m_rdata = rdata;
    m_rd = rd; m_regwrite = rw; m_wbsel = wbsel; m_ldtype = ld;
  endtask

  task automatic test_reset();
    logic [31:0] exp_cnt;
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h0000_1000, 32'h0000_1234, 32'hDEAD_BEEF, 5'd7, 1'b1, 2'd0, 3'd0);
    tick(); tick();
    total++; if (w_valid !== 1'b0)    begin bad++; $display("[TB] FAIL rst_wvalid got=%0b exp=0", w_valid); end
    total++; if (regwrite !== 1'b0)   begin bad++; $display("[TB] FAIL rst_regwrite got=%0b exp=0", regwrite); end
    total++; if (writerd !== 5'd0)    begin bad++; $display("[TB] FAIL rst_writerd got=%0d exp=0", writerd); end
    total++; if (writedata !== 32'h0) begin bad++; $display("[TB] FAIL rst_writedata got=%h exp=0", writedata); end
    total++; if (pcout_W !== 32'h0)   begin bad++; $display("[TB] FAIL rst_pcout got=%h exp=0", pcout_W); end
    total++; if (retire_cnt !== 32'h0) begin bad++; $display("[TB] FAIL rst_retire got=%0d exp=0", retire_cnt); end
    reset = 1'b1;
    tick();
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    total++; if (w_valid !== 1'b1)    begin bad++; $display("[TB] FAIL first_wvalid got=%0b exp=1", w_valid); end
    total++; if (regwrite !== 1'b1)   begin bad++; $display("[TB] FAIL first_regwrite got=%0b exp=1", regwrite); end
    total++; if (writerd !== 5'd7)    begin bad++; $display("[TB] FAIL first_writerd got=%0d exp=7", writerd); end
    total++; if (writedata !== 32'h0000_1234) begin bad++; $display("[TB] FAIL first_writedata got=%h exp=00001234", writedata); end
    total++; if (pcout_W !== 32'h0000_1000)   begin bad++; $display("[TB] FAIL first_pcout got=%h exp=00001000", pcout_W); end
    total++; if (retire_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL first_retire got=%0d exp=%0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_load_byte();
    // {ldtype, addr, expected} for rdata = 80FF7F01
    logic [2:0]  ld  [6] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2};
    logic [31:0] adr [6] = '{32'h1003, 32'h1003, 32'h1000, 32'h1001, 32'h1002, 32'h1002};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0001,
                             32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h2000, adr[i], 32'h80FF_7F01, 5'd5, 1'b1, 2'd1, ld[i]);
      tick();
      total++; if (writedata !== exp[i]) begin bad++; $display("[TB] FAIL lb_data[%0d] got=%h exp=%h", i, writedata, exp[i]); end
    end
    total++; if (writerd !== 5'd5)  begin bad++; $display("[TB] FAIL lb_writerd got=%0d exp=5", writerd); end
    total++; if (regwrite !== 1'b1) begin bad++; $display("[TB] FAIL lb_regwrite got=%0b exp=1", regwrite); end
  endtask

  task automatic test_load_half();
    // rdata = 80011234; ldtype 7 falls back to LW
    logic [2:0]  ld  [7] = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd0, 3'd7, 3'd4};
    logic [31:0] adr [7] = '{32'h2, 32'h2, 32'h1, 32'h1, 32'h3, 32'h1, 32'h3};
    logic [31:0] exp [7] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_1234, 32'h0000_1234,
                             32'h8001_1234, 32'h8001_1234, 32'h0000_8001};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h2004, adr[i], 32'h8001_1234, 5'd6, 1'b1, 2'd1, ld[i]);
      tick();
      total++; if (writedata !== exp[i]) begin bad++; $display("[TB] FAIL lh_data[%0d] got=%h exp=%h", i, writedata, exp[i]); end
    end
  endtask

  task automatic test_link();
    drive(1'b1, 32'h0000_3000, 32'h5555_AAAA, 32'h0, 5'd31, 1'b1, 2'd2, 3'd0);
    tick();
    total++; if (writedata !== 32'h0000_3008) begin bad++; $display("[TB] FAIL link_data got=%h exp=00003008", writedata); end
    drive(1'b1, 32'hFFFF_FFF8, 32'h5555_AAAA, 32'h0, 5'd31, 1'b1, 2'd2, 3'd0);
    tick();
    total++; if (writedata !== 32'h0) begin bad++; $display("[TB] FAIL link_wrap got=%h exp=00000000", writedata); end
    total++; if (pcout_W !== 32'hFFFF_FFF8) begin bad++; $display("[TB] FAIL link_pcout got=%h exp=fffffff8", pcout_W); end
    drive(1'b1, 32'h0000_3000, 32'h5555_AAAA, 32'h1111_1111, 5'd3, 1'b1, 2'd3, 3'd0);
    tick();
    total++; if (writedata !== 32'h5555_AAAA) begin bad++; $display("[TB] FAIL wbsel3_data got=%h exp=5555aaaa", writedata); end
  endtask

  task automatic test_no_write();
    // {valid, rd, regwrite} cases that must never assert regwrite
    logic       v  [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0] rd [3] = '{5'd0, 5'd9, 5'd9};
    logic       rw [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(v[i], 32'h4000, 32'h77, 32'h0, rd[i], rw[i], 2'd0, 3'd0);
      tick();
      total++; if (regwrite !== 1'b0) begin bad++; $display("[TB] FAIL nowr_regwrite[%0d] got=%0b exp=0", i, regwrite); end
      total++; if (writerd !== 5'd0)  begin bad++; $display("[TB] FAIL nowr_writerd[%0d] got=%0d exp=0", i, writerd); end
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h0000_5000, 32'h0000_ABCD, 32'h0, 5'd9, 1'b1, 2'd0, 3'd0);
    tick();
    stall = 1'b1;
    drive(1'b1, 32'h0000_6000, 32'h0000_1111, 32'h0, 5'd10, 1'b1, 2'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (writedata !== 32'h0000_ABCD) begin bad++; $display("[TB] FAIL stall_data[%0d] got=%h exp=0000abcd", i, writedata); end
      total++; if (writerd !== 5'd9 || regwrite !== 1'b1) begin bad++; $display("[TB] FAIL stall_wr[%0d] got=%0d/%0b exp=9/1", i, writerd, regwrite); end
      total++; if (pcout_W !== 32'h0000_5000) begin bad++; $display("[TB] FAIL stall_pc[%0d] got=%h exp=00005000", i, pcout_W); end
    end
    stall = 1'b0;
    tick();
    total++; if (writedata !== 32'h0000_1111 || writerd !== 5'd10) begin bad++; $display("[TB] FAIL unstall got=%h/%0d exp=00001111/10", writedata, writerd); end
  endtask

  task automatic test_stall_flush();
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h0000_7000, 32'h0000_2222, 32'h0, 5'd11, 1'b1, 2'd0, 3'd0);
    tick();
    stall = 1'b0; flush = 1'b0;
    total++; if (w_valid !== 1'b0 || regwrite !== 1'b0) begin bad++; $display("[TB] FAIL flush_bubble got=%0b/%0b exp=0/0", w_valid, regwrite); end
    total++; if (writedata !== 32'h0 || pcout_W !== 32'h0 || writerd !== 5'd0) begin bad++; $display("[TB] FAIL flush_fields got=%h/%h/%0d exp=0/0/0", writedata, pcout_W, writerd); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h0000_8000, 32'h0000_3333, 32'h0, 5'd12, 1'b1, 2'd0, 3'd0);
    tick();
    stall = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    stall = 1'b0;
    total++; if (w_valid !== 1'b0 || regwrite !== 1'b0 || writedata !== 32'h0) begin bad++; $display("[TB] FAIL rst_stall got=%0b/%0b/%h exp=0/0/0", w_valid, regwrite, writedata); end
  endtask

  task automatic test_retire();
    logic [31:0] exp_cnt;
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h9000 + 32'(4 * i), 32'(i), 32'h0, 5'd1, 1'b1, 2'd0, 3'd0);
      tick();
    end
    stall = 1'b1; tick(); tick(); stall = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    m_valid = 1'b0;
    tick();
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    total++; if (retire_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL retire_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_link();
    test_no_write();
    test_stall();
    test_stall_flush();
    test_reset_mid_stall();
    test_retire();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
